gba_ds_fifo: RTL and testbench
==============================

GBA_DS_FIFO -- requirements
Module: gba_ds_fifo

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'h0A0, the byte address of this FIFO's 32-bit write port; 12'h0A4 selects the second channel.
REQ-002 SHALL have port gba_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port io_addr  input  12  the IO byte address; a word hit is io_addr[11:2] == BASE_ADDR[11:2].
REQ-005 SHALL have port io_write  input  1  the single-cycle write strobe.
REQ-006 SHALL have port bus_be  input  4  the byte enables of the write.
REQ-007 SHALL have port bus_wdata  input  32  the write data.
REQ-008 SHALL have port FIFO_re  input  1  the pop strobe from the direct-sound consumer.
REQ-009 SHALL have port FIFO_clr  input  1  the flush strobe from the direct-sound consumer.
REQ-010 SHALL have port FIFO_size  output  4  the number of stored words, 0..8.
REQ-011 SHALL have port FIFO_val  output  32  the head word.
REQ-012 SHALL have port overflow  output  1  a one-cycle pulse when a committed word is dropped.

Function
REQ-013 SHALL store 8 words of 32 bits in a circular buffer with a 3-bit write pointer, a 3-bit read pointer and a 4-bit count.
REQ-014 SHALL commit bus_wdata as one word when io_write=1, the word hits, and bus_be=4'b1111.
REQ-015 SHALL latch bus_wdata[15:0] into a staging register and set staged_valid, without committing, when the word hits and bus_be=4'b0011.
REQ-016 SHALL commit {bus_wdata[31:16], staging} when the word hits and bus_be=4'b1100, then clear staged_valid; if staged_valid=0 it SHALL use 16'h0000 as the low half.
REQ-017 SHALL ignore every other bus_be pattern and every non-hitting write, with no state change.
REQ-018 SHALL write the word at the write pointer on a commit with count<8, then increment the write pointer (wrapping 7->0) and the count.
REQ-019 SHALL discard a commit made while count==8 with no pop in the same cycle, and SHALL pulse overflow=1 for exactly that cycle.
REQ-020 SHALL, on FIFO_re=1 with count>0, increment the read pointer (wrapping 7->0) and decrement the count; FIFO_re with count==0 SHALL be ignored.
REQ-021 SHALL, on a simultaneous commit and valid pop, perform both: pointers advance and count is unchanged, including at count==8, with no overflow.
REQ-022 SHALL, on a simultaneous commit and pop at count==0, accept the commit and ignore the pop, giving count=1.
REQ-023 SHALL, on FIFO_clr=1, set both pointers, the count, staged_valid and the staging register to 0 on that edge; the clear SHALL take priority, and any same-cycle commit, pop or half-write SHALL be discarded with overflow=0.
REQ-024 SHALL drive FIFO_size equal to the registered count.
REQ-025 SHALL drive FIFO_val combinationally as mem[read pointer] when count>0 and 32'h0 when count==0.
REQ-026 SHALL make a word written at edge N visible on FIFO_val/FIFO_size after edge N, with no extra latency.
REQ-027 SHALL keep FIFO_size always in 0..8, with no count wrap.

Reset
REQ-028 SHALL, while reset=0, asynchronously force the pointers, count, staging register, staged_valid and overflow to 0, giving FIFO_size=0, FIFO_val=0 and overflow=0.
REQ-029 SHALL need no reset of buffer contents, since FIFO_val is masked to 0 when empty.
REQ-030 SHALL discard, when reset is asserted mid-operation, any pending staged half-word and all stored words; the first write after release SHALL land in slot 0.

Verification
REQ-031 Bench: 3 full-word writes 11111111, 22222222, 33333333 -> FIFO_size=3, FIFO_val=11111111; FIFO_re x3 -> values pop in order, then FIFO_size=0, FIFO_val=0.
REQ-032 Bench: half write be=0011 data xxxxBEEF, then be=1100 data DEADxxxx -> one word DEADBEEF, FIFO_size=1; a lone be=1100 write of 12340000 -> word 12340000.
REQ-033 Bench: 9 word writes with no pops -> FIFO_size=8, a single overflow pulse on the 9th, and the head still equals the 1st word.
REQ-034 Bench: at FIFO_size=8, a write and FIFO_re in the same cycle -> FIFO_size=8, overflow=0, the head advances to the 2nd word, and the tail holds the new word after 8 pops.
REQ-035 Bench: 12 pushes interleaved with 12 pops at count 1 (pointer wrap) -> data order preserved; FIFO_clr with a same-cycle write -> FIFO_size=0 next cycle and the write discarded.
REQ-036 Bench: reset=0 asserted mid-stream at count=5 with a staged half pending -> FIFO_size=0 immediately, without waiting for a clock; after release, be=1100 write AAAA0000 -> word AAAA0000.

Source files
------------

// File: rtl/gba_ds_fifo.sv
// Direct-sound sample FIFO: eight 32-bit words fed from a word-addressed IO port,
// with half-word staging so a CPU can fill a word using two 16-bit stores.
module gba_ds_fifo #(
    parameter logic [11:0] BASE_ADDR = 12'h0A0
) (
    input  logic        gba_clk,
    input  logic        reset,
    input  logic [11:0] io_addr,
    input  logic        io_write,
    input  logic [3:0]  bus_be,
    input  logic [31:0] bus_wdata,
    input  logic        FIFO_re,
    input  logic        FIFO_clr,
    output logic [3:0]  FIFO_size,
    output logic [31:0] FIFO_val,
    output logic        overflow
);

    localparam logic [3:0] DEPTH = 4'd8;

    logic [31:0] mem [8];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [3:0]  count;
    logic [15:0] staging;
    logic        staged_valid;

    logic        hit;
    logic        full_wr;
    logic        lo_wr;
    logic        hi_wr;
    logic        commit;
    logic        pop_ok;
    logic        push_ok;
    logic        drop;
    logic [31:0] commit_data;
    logic        addr_unused;

    // Byte lanes inside the word are selected by bus_be, not by the low address bits.
    assign addr_unused = &{1'b0, io_addr[1:0]};

    assign hit     = io_write && (io_addr[11:2] == BASE_ADDR[11:2]);
    assign full_wr = hit && (bus_be == 4'b1111);
    assign lo_wr   = hit && (bus_be == 4'b0011);
    assign hi_wr   = hit && (bus_be == 4'b1100);
    assign commit  = full_wr || hi_wr;
    assign pop_ok  = FIFO_re && (count != 4'd0);
    // A pop in the same cycle frees the slot, so a commit at full is still accepted.
    assign push_ok = commit && ((count != DEPTH) || pop_ok);
    assign drop    = commit && (count == DEPTH) && !pop_ok;

    // NOTE: every path assigns commit_data, so this combinational select cannot infer a latch.
    always_comb begin
        commit_data = bus_wdata;
        if (hi_wr) begin
            commit_data = {bus_wdata[31:16], staged_valid ? staging : 16'h0000};
        end
    end

    // NOTE: the storage array has no reset; FIFO_val is masked while empty, so stale contents never show.
    always_ff @(posedge gba_clk) begin
        if (push_ok && !FIFO_clr) begin
            mem[wr_ptr] <= commit_data;
        end
    end

    // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
    always_ff @(posedge gba_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= 3'd0;
            rd_ptr       <= 3'd0;
            count        <= 4'd0;
            staging      <= 16'h0000;
            staged_valid <= 1'b0;
            overflow     <= 1'b0;
        end else if (FIFO_clr) begin
            wr_ptr       <= 3'd0;
            rd_ptr       <= 3'd0;
            count        <= 4'd0;
            staging      <= 16'h0000;
            staged_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            overflow <= drop;
            if (lo_wr) begin
                staging      <= bus_wdata[15:0];
                staged_valid <= 1'b1;
            end else if (hi_wr) begin
                staged_valid <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    assign FIFO_size = count;
    assign FIFO_val  = (count != 4'd0) ? mem[rd_ptr] : 32'h0000_0000;

endmodule

// File: tb/tb_gba_ds_fifo.sv
// Directed self-checking bench for gba_ds_fifo: word and half-word writes,
// full/overflow handling, pointer wrap, flush and asynchronous reset.
module tb_gba_ds_fifo;

    logic        gba_clk;
    logic        reset;
    logic [11:0] io_addr;
    logic        io_write;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        FIFO_re;
    logic        FIFO_clr;
    logic [3:0]  FIFO_size;
    logic [31:0] FIFO_val;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    gba_ds_fifo #(.BASE_ADDR(12'h0A0)) dut (
        .gba_clk   (gba_clk),
        .reset     (reset),
        .io_addr   (io_addr),
        .io_write  (io_write),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .FIFO_re   (FIFO_re),
        .FIFO_clr  (FIFO_clr),
        .FIFO_size (FIFO_size),
        .FIFO_val  (FIFO_val),
        .overflow  (overflow)
    );

    initial gba_clk = 1'b0;
    always #5 gba_clk = ~gba_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, take the rising edge, sample 1ns later with inputs idle.
    task automatic cyc(input logic [11:0] addr, input logic wr, input logic [3:0] be,
                       input logic [31:0] d, input logic re, input logic clr);
        io_addr   = addr;
        io_write  = wr;
        bus_be    = be;
        bus_wdata = d;
        FIFO_re   = re;
        FIFO_clr  = clr;
        @(posedge gba_clk);
        #1;
        io_write  = 1'b0;
        bus_be    = 4'b0000;
        FIFO_re   = 1'b0;
        FIFO_clr  = 1'b0;
    endtask

    task automatic wr_word(input logic [31:0] d);
        cyc(12'h0A0, 1'b1, 4'b1111, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(12'h0A0, 1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cyc(12'h0A0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        io_addr = 12'h0A0;
        io_write = 1'b0;
        bus_be = 4'b0000;
        bus_wdata = 32'h0;
        FIFO_re = 1'b0;
        FIFO_clr = 1'b0;
        #2;
        check("reset_size", {28'h0, FIFO_size}, 32'd0);
        check("reset_val", FIFO_val, 32'h0);
        check("reset_ovf", {31'h0, overflow}, 32'd0);
        repeat (2) @(posedge gba_clk);
        #1 reset = 1'b1;

        // Three full words, including one at a byte offset inside the hit word.
        wr_word(32'h11111111);
        cyc(12'h0A3, 1'b1, 4'b1111, 32'h22222222, 1'b0, 1'b0);
        wr_word(32'h33333333);
        check("three_size", {28'h0, FIFO_size}, 32'd3);
        check("three_head", FIFO_val, 32'h11111111);
        pop();
        check("pop1_val", FIFO_val, 32'h22222222);
        pop();
        check("pop2_val", FIFO_val, 32'h33333333);
        pop();
        check("pop3_size", {28'h0, FIFO_size}, 32'd0);
        check("pop3_val", FIFO_val, 32'h0);
        pop();
        check("empty_pop_size", {28'h0, FIFO_size}, 32'd0);

        // Ignored writes: other channel, odd byte enables, no strobe.
        cyc(12'h0A4, 1'b1, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b0);
        cyc(12'h0A0, 1'b1, 4'b0001, 32'hFFFFFFFF, 1'b0, 1'b0);
        cyc(12'h0A0, 1'b1, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0);
        cyc(12'h0A0, 1'b0, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("ignored_size", {28'h0, FIFO_size}, 32'd0);

        // Half-word assembly.
        cyc(12'h0A0, 1'b1, 4'b0011, 32'h5A5ABEEF, 1'b0, 1'b0);
        check("lo_no_commit", {28'h0, FIFO_size}, 32'd0);
        cyc(12'h0A2, 1'b1, 4'b1100, 32'hDEAD0000, 1'b0, 1'b0);
        check("half_size", {28'h0, FIFO_size}, 32'd1);
        check("half_word", FIFO_val, 32'hDEADBEEF);
        pop();
        cyc(12'h0A2, 1'b1, 4'b1100, 32'h12345678, 1'b0, 1'b0);
        check("lone_hi_word", FIFO_val, 32'h12340000);
        pop();

        // Fill to eight, then overflow on the ninth.
        for (int i = 1; i <= 8; i++) wr_word(32'hA0000000 + 32'(i));
        check("full_size", {28'h0, FIFO_size}, 32'd8);
        check("full_no_ovf", {31'h0, overflow}, 32'd0);
        wr_word(32'hA0000009);
        check("ovf_pulse", {31'h0, overflow}, 32'd1);
        check("ovf_size", {28'h0, FIFO_size}, 32'd8);
        check("ovf_head", FIFO_val, 32'hA0000001);
        idle();
        check("ovf_one_cycle", {31'h0, overflow}, 32'd0);

        // Simultaneous write and pop while full.
        cyc(12'h0A0, 1'b1, 4'b1111, 32'hB0000000, 1'b1, 1'b0);
        check("wrpop_size", {28'h0, FIFO_size}, 32'd8);
        check("wrpop_ovf", {31'h0, overflow}, 32'd0);
        check("wrpop_head", FIFO_val, 32'hA0000002);
        for (int i = 0; i < 8; i++) begin
            check("drain_val", FIFO_val, (i < 7) ? 32'hA0000002 + 32'(i) : 32'hB0000000);
            pop();
        end
        check("drain_size", {28'h0, FIFO_size}, 32'd0);

        // Push/pop alternation at count 1 walks the pointers around the ring.
        for (int i = 0; i < 12; i++) begin
            wr_word(32'hC0000000 + 32'(i));
            check("wrap_size", {28'h0, FIFO_size}, 32'd1);
            check("wrap_val", FIFO_val, 32'hC0000000 + 32'(i));
            pop();
        end
        check("wrap_empty", {28'h0, FIFO_size}, 32'd0);

        // Commit and pop together on an empty FIFO: the pop is ignored.
        cyc(12'h0A0, 1'b1, 4'b1111, 32'hD0000001, 1'b1, 1'b0);
        check("empty_wrpop_size", {28'h0, FIFO_size}, 32'd1);
        check("empty_wrpop_val", FIFO_val, 32'hD0000001);

        // Flush wins over a same-cycle write and clears a pending half.
        wr_word(32'hD0000002);
        cyc(12'h0A0, 1'b1, 4'b0011, 32'h00007777, 1'b0, 1'b0);
        cyc(12'h0A0, 1'b1, 4'b1111, 32'hEEEEEEEE, 1'b0, 1'b1);
        check("clr_size", {28'h0, FIFO_size}, 32'd0);
        check("clr_val", FIFO_val, 32'h0);
        check("clr_ovf", {31'h0, overflow}, 32'd0);
        cyc(12'h0A0, 1'b1, 4'b1100, 32'h55550000, 1'b0, 1'b0);
        check("clr_staging", FIFO_val, 32'h55550000);
        check("clr_then_size", {28'h0, FIFO_size}, 32'd1);
        pop();

        // Asynchronous reset mid-stream with a staged half pending.
        for (int i = 0; i < 5; i++) wr_word(32'hF0000000 + 32'(i));
        cyc(12'h0A0, 1'b1, 4'b0011, 32'h00009999, 1'b0, 1'b0);
        check("pre_reset_size", {28'h0, FIFO_size}, 32'd5);
        #2 reset = 1'b0;
        #1;
        check("async_reset_size", {28'h0, FIFO_size}, 32'd0);
        check("async_reset_val", FIFO_val, 32'h0);
        @(posedge gba_clk);
        #1 reset = 1'b1;
        cyc(12'h0A0, 1'b1, 4'b1100, 32'hAAAA0000, 1'b0, 1'b0);
        check("post_reset_word", FIFO_val, 32'hAAAA0000);
        check("post_reset_size", {28'h0, FIFO_size}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
